// File: rtl/alu3_serial_seq.sv
// Bit-serial 3-bit ALU (XOR/AND/ADD/SUB); one result bit per cycle, LSB first, carry/borrow flag in out_result[3].
// Latency: out_valid rises 3 cycles after the accepting edge; one command per 5 cycles with out_ready held high.
// Backpressure: in_ready only in IDLE; the result is held stable in DONE until out_ready is seen high at an edge.
//
// Ports:
//   clk, rst_n            single clock, asynchronous active-low reset
//   in_valid/in_ready     command handshake; in_op (00 XOR, 01 AND, 10 ADD, 11 SUB), in_a, in_b (3-bit unsigned)
//   out_valid/out_ready   result handshake; out_result[2:0] = result, out_result[3] = carry (ADD) / borrow (SUB)
//   out_zero              present only when ALU3_SERIAL_ZFLAG_EN is defined: out_result[2:0] == 0
module alu3_serial_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_op,
    input  logic [2:0] in_a,
    input  logic [2:0] in_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_result
`ifdef ALU3_SERIAL_ZFLAG_EN
    ,
    output logic       out_zero
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] OP_XOR = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    logic [1:0] state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       carry_q, carry_d;
    logic [1:0] op_q, op_d;
    logic [2:0] a_q, a_d;
    logic [2:0] b_q, b_d;
    // Low result bits collect here so out_result keeps the previous value until the final bit lands.
    logic [1:0] acc_q, acc_d;
    logic [3:0] res_q, res_d;
`ifdef ALU3_SERIAL_ZFLAG_EN
    logic       zero_q, zero_d;
`endif

    logic a_bit;
    logic b_bit;
    logic b_eff;
    logic sum_bit;
    logic carry_nxt;
    logic r_bit;
    logic flag;

    // Operand bit select for the current counter value.
    always_comb begin
        a_bit = a_q[2];
        b_bit = b_q[2];
        case (cnt_q)
            2'd0: begin
                a_bit = a_q[0];
                b_bit = b_q[0];
            end
            2'd1: begin
                a_bit = a_q[1];
                b_bit = b_q[1];
            end
            default: begin
                a_bit = a_q[2];
                b_bit = b_q[2];
            end
        endcase
    end

    // SUB is ADD of the inverted subtrahend with carry-in 1 (loaded at accept).
    assign b_eff     = (op_q == OP_SUB) ? ~b_bit : b_bit;
    assign sum_bit   = a_bit ^ b_eff ^ carry_q;
    assign carry_nxt = (a_bit & b_eff) | (a_bit & carry_q) | (b_eff & carry_q);

    always_comb begin
        r_bit = sum_bit;
        flag  = 1'b0;
        case (op_q)
            OP_XOR: r_bit = a_bit ^ b_bit;
            OP_AND: r_bit = a_bit & b_bit;
            OP_ADD: flag  = carry_nxt;
            default: flag = ~carry_nxt;   // SUB: no final carry means a borrow occurred
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
`ifdef ALU3_SERIAL_ZFLAG_EN
        zero_d  = zero_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d    = in_op;
                    a_d     = in_a;
                    b_d     = in_b;
                    cnt_d   = 2'd0;
                    carry_d = in_op[1] & in_op[0];
                    acc_d   = 2'b00;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                carry_d = carry_nxt;
                cnt_d   = cnt_q + 2'd1;
                case (cnt_q)
                    2'd0: acc_d[0] = r_bit;
                    2'd1: acc_d[1] = r_bit;
                    default: begin
                        res_d   = {flag, r_bit, acc_q};
`ifdef ALU3_SERIAL_ZFLAG_EN
                        zero_d  = ({r_bit, acc_q} == 3'b000);
`endif
                        cnt_d   = 2'd0;
                        state_d = ST_DONE;
                    end
                endcase
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            carry_q <= 1'b0;
            op_q    <= 2'b00;
            a_q     <= 3'b000;
            b_q     <= 3'b000;
            acc_q   <= 2'b00;
            res_q   <= 4'b0000;
`ifdef ALU3_SERIAL_ZFLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
`ifdef ALU3_SERIAL_ZFLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign out_result = res_q;
`ifdef ALU3_SERIAL_ZFLAG_EN
    assign out_zero   = zero_q;
`endif

endmodule

// File: tb/tb_alu3_serial_seq.sv
// Testbench for alu3_serial_seq: directed cases plus randomized commands with a queue-based scoreboard.
// Expected results come from plain integer arithmetic; a monitor checks latency, result, hold and handshakes.
// out_ready is either driven directly or randomized to exercise result backpressure.
module tb_alu3_serial_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_op = 2'b00;
    logic [2:0] in_a = 3'b000;
    logic [2:0] in_b = 3'b000;
    logic       out_ready = 1'b1;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_result;
`ifdef ALU3_SERIAL_ZFLAG_EN
    logic       out_zero;
`endif

    alu3_serial_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
`ifdef ALU3_SERIAL_ZFLAG_EN
        ,
        .out_zero   (out_zero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] res;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   rand_ordy = 1'b0;
    bit   prev_vld = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rand_ordy) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Reference: whole-word arithmetic, result modulo 8, flag = carry out / borrow.
    function automatic logic [3:0] ref_model(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
        int ia, ib, r;
        logic [3:0] res;
        ia = int'(a);
        ib = int'(b);
        res = 4'b0000;
        case (op)
            2'b00: res = {1'b0, a ^ b};
            2'b01: res = {1'b0, a & b};
            2'b10: begin
                r = ia + ib;
                res[2:0] = r[2:0];
                res[3] = (r > 7);
            end
            default: begin
                r = (ia - ib + 8) % 8;
                res[2:0] = r[2:0];
                res[3] = (ia < ib);
            end
        endcase
        return res;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Offer one command; after acceptance optionally scramble inputs during EXEC.
    task automatic send(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b, input bit junk);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        for (int k = 0; k < 50; k++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready never seen, op %0d a %0d b %0d", op, a, b);
            in_valid = 1'b0;
            return;
        end
        e.res = ref_model(op, a, b);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        if (junk) begin
            for (int k = 0; k < 3; k++) begin
                in_valid = 1'($urandom_range(0, 1));
                in_op = 2'($urandom_range(0, 3));
                in_a = 3'($urandom_range(0, 7));
                in_b = 3'($urandom_range(0, 7));
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int k = 0; k < max_cyc && sb.size() != 0; k++) @(posedge clk);
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    // Monitor: samples at the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vld = 1'b0;
        end else begin
            if (out_valid) begin
                check("in_ready_low_in_done", int'(in_ready), 0);
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: out_valid with result %b but nothing expected", out_result);
                end else begin
                    if (!prev_vld) check("latency", cyc - sb[0].acc, 3);
                    check("result", int'(out_result), int'(sb[0].res));
`ifdef ALU3_SERIAL_ZFLAG_EN
                    check("zero_flag", int'(out_zero), int'(sb[0].res[2:0] == 3'b000));
`endif
                    if (out_ready) void'(sb.pop_front());
                end
            end
            prev_vld = out_valid;
        end
    end

    initial begin
        bit seen;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_result", int'(out_result), 0);
`ifdef ALU3_SERIAL_ZFLAG_EN
        check("rst_out_zero", int'(out_zero), 0);
`endif
        rst_n = 1'b1;

        // Directed vectors
        send(2'b10, 3'd3, 3'd5, 1'b0);
        send(2'b11, 3'd5, 3'd3, 1'b0);
        send(2'b11, 3'd3, 3'd5, 1'b0);
        send(2'b01, 3'd6, 3'd3, 1'b0);
        send(2'b00, 3'd6, 3'd3, 1'b0);
        send(2'b11, 3'd4, 3'd1, 1'b1);
        wait_drain(50);

        // Hold under backpressure, second command ignored
        out_ready = 1'b0;
        send(2'b10, 3'd7, 3'd7, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk); #1;
            seen = out_valid;
        end
        check("hold_reached_done", int'(seen), 1);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_op = 2'($urandom_range(0, 3));
            in_a = 3'($urandom_range(0, 7));
            in_b = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_out_valid", int'(out_valid), 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", int'(in_ready), 1);
        check("release_out_valid", int'(out_valid), 0);
        repeat (4) @(posedge clk);
        #1;
        check("hold_queue_empty", sb.size(), 0);

        // Reset in the middle of EXEC
        @(posedge clk); #1;
        check("pre_rst_idle", int'(in_ready), 1);
        in_valid = 1'b1;
        in_op = 2'b11;
        in_a = 3'd3;
        in_b = 3'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_exec_busy", int'(in_ready), 0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_result", int'(out_result), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(2'b10, 3'd1, 3'd1, 1'b0);
        wait_drain(50);

        // Randomized traffic with random backpressure
        rand_ordy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)));
        end
        wait_drain(400);
        rand_ordy = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
